// File: rtl/l2_pkg.sv
// Shared definitions for the L2 data array: default geometry, controller
// state encoding and the byte-parity helper used by the optional parity path.
package l2_pkg;

   localparam int L2_LINE_W = 512;
   localparam int L2_BEAT_W = 128;
   localparam int L2_SETS   = 256;
   localparam int L2_WAYS   = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REFILL  = 2'd1,
      EV_RD   = 2'd2,
      EV_SEND = 2'd3
   } l2_state_t;

   // Even parity over one byte: stored bit makes the 9-bit total even.
   function automatic logic byte_par(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/l2_data_ram.sv
// Single-port L2 data storage, SETS*WAYS lines of LINE_W bits, per-byte write
// enable, registered read, no reset. With L2_DATA_PARITY_EN defined, one
// parity bit per byte is stored under the same byte enables.
module l2_data_ram #(
   parameter int LINE_W = 512,
   parameter int SETS   = 256,
   parameter int WAYS   = 4
) (
   input  logic                              clk,
   input  logic                              en,
   input  logic                              we,
   input  logic [$clog2(SETS*WAYS)-1:0]      addr,
   input  logic [LINE_W/8-1:0]               be,
   input  logic [LINE_W-1:0]                 wdata,
`ifdef L2_DATA_PARITY_EN
   input  logic [LINE_W/8-1:0]               wpar,
   output logic [LINE_W/8-1:0]               rpar,
`endif
   output logic [LINE_W-1:0]                 rdata
);

   localparam int NB    = LINE_W / 8;
   localparam int DEPTH = SETS * WAYS;

   logic [LINE_W-1:0] mem [DEPTH];

   // Byte-masked write or registered read; output holds when idle or writing.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < NB; b++)
               if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end else begin
            rdata <= mem[addr];
         end
      end
   end

`ifdef L2_DATA_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];

   // Parity bits follow exactly the data byte enables.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < NB; b++)
               if (be[b]) par_mem[addr][b] <= wpar[b];
         end else begin
            rpar <= par_mem[addr];
         end
      end
   end
`endif

endmodule

// File: rtl/l2_data_array_bw.sv
// L2 data array: one-cycle registered line reads, byte-masked update hits,
// multi-beat refill into and eviction out of the array.
// Optional feature: L2_DATA_PARITY_EN adds per-byte parity storage and the
// perr pulse; when undefined perr is tied low.
module l2_data_array_bw
   import l2_pkg::*;
#(
   parameter int LINE_W = L2_LINE_W,
   parameter int BEAT_W = L2_BEAT_W,
   parameter int SETS   = L2_SETS,
   parameter int WAYS   = L2_WAYS
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic [$clog2(SETS)-1:0]   index,
   input  logic [$clog2(WAYS)-1:0]   way,
   input  logic                      rd_req,
   input  logic                      upd_req,
   input  logic [LINE_W-1:0]         upd_data,
   input  logic [LINE_W/8-1:0]       upd_be,
   input  logic                      refill_start,
   input  logic                      evict_start,
   output logic                      ready,
   output logic                      rd_valid,
   output logic [LINE_W-1:0]         rd_data,
   input  logic                      mem_beat_valid,
   input  logic [BEAT_W-1:0]         mem_beat_data,
   output logic                      mem_beat_ready,
   output logic                      refill_done,
   output logic                      wb_beat_valid,
   output logic [BEAT_W-1:0]         wb_beat_data,
   output logic                      wb_beat_last,
   input  logic                      wb_beat_ready,
   output logic                      perr
);

   localparam int NB    = LINE_W / 8;
   localparam int BEATS = LINE_W / BEAT_W;
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int AW    = IDX_W + WAY_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   l2_state_t                     state;
   logic [CNT_W-1:0]              cnt, cnt_nxt;
   logic [IDX_W-1:0]              idx_q;
   logic [WAY_W-1:0]              way_q;
   logic                          rd_pend, done_pend;
   logic [BEATS-1:0][BEAT_W-1:0]  stage, refill_line;

   logic                          acc_ev, acc_rf, acc_up, acc_rd, refill_fin;
   logic                          ram_en, ram_we, par_bad;
   logic [AW-1:0]                 ram_addr;
   logic [NB-1:0]                 ram_be;
   logic [LINE_W-1:0]             ram_wdata, ram_rdata;

   // One command per cycle, evict > refill > update > read; losers are dropped.
   assign acc_ev = ready && evict_start;
   assign acc_rf = ready && !evict_start && refill_start;
   assign acc_up = ready && !evict_start && !refill_start && upd_req;
   assign acc_rd = ready && !evict_start && !refill_start && !upd_req && rd_req;

   assign refill_fin = (state == REFILL) && mem_beat_valid && (cnt == LAST);
   assign cnt_nxt    = cnt + CNT_W'(1);

   // Final refill beat goes straight into the write, not via the buffer.
   always_comb begin
      refill_line           = stage;
      refill_line[BEATS-1]  = mem_beat_data;
   end

   // Single RAM port: IDLE commands use the live address, refill commit the latched one.
   assign ram_en    = acc_ev || acc_up || acc_rd || refill_fin;
   assign ram_we    = acc_up || refill_fin;
   assign ram_addr  = refill_fin ? {idx_q, way_q} : {index, way};
   assign ram_be    = refill_fin ? '1 : upd_be;
   assign ram_wdata = refill_fin ? refill_line : upd_data;

`ifdef L2_DATA_PARITY_EN
   logic [NB-1:0] ram_wpar, ram_rpar, par_chk;

   for (genvar b = 0; b < NB; b++) begin : g_par
      assign ram_wpar[b] = byte_par(ram_wdata[b*8 +: 8]);
      assign par_chk[b]  = byte_par(ram_rdata[b*8 +: 8]) ^ ram_rpar[b];
   end
   assign par_bad = |par_chk;
`else
   assign par_bad = 1'b0;
`endif

   l2_data_ram #(
      .LINE_W (LINE_W),
      .SETS   (SETS),
      .WAYS   (WAYS)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .be    (ram_be),
      .wdata (ram_wdata),
`ifdef L2_DATA_PARITY_EN
      .wpar  (ram_wpar),
      .rpar  (ram_rpar),
`endif
      .rdata (ram_rdata)
   );

   // Staging buffer: collects refill beats, or captures the evicted line in EV_RD.
   always_ff @(posedge clk) begin
      if (state == REFILL && mem_beat_valid)
         stage[cnt] <= mem_beat_data;
      else if (state == EV_RD)
         stage <= ram_rdata;
   end

   // Controller FSM with registered outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state          <= IDLE;
         cnt            <= '0;
         idx_q          <= '0;
         way_q          <= '0;
         rd_pend        <= 1'b0;
         done_pend      <= 1'b0;
         ready          <= 1'b1;
         rd_valid       <= 1'b0;
         rd_data        <= '0;
         mem_beat_ready <= 1'b0;
         refill_done    <= 1'b0;
         wb_beat_valid  <= 1'b0;
         wb_beat_last   <= 1'b0;
         wb_beat_data   <= '0;
         perr           <= 1'b0;
      end else begin
         rd_valid    <= 1'b0;
         refill_done <= 1'b0;
         perr        <= 1'b0;
         rd_pend     <= acc_rd;
         if (rd_pend) begin
            rd_valid <= 1'b1;
            rd_data  <= ram_rdata;
            perr     <= par_bad;
         end
         case (state)
            IDLE: begin
               if (done_pend) begin
                  // Commit cycle after the final refill beat.
                  done_pend   <= 1'b0;
                  ready       <= 1'b1;
                  refill_done <= 1'b1;
               end else if (acc_ev) begin
                  idx_q <= index;
                  way_q <= way;
                  ready <= 1'b0;
                  state <= EV_RD;
               end else if (acc_rf) begin
                  idx_q          <= index;
                  way_q          <= way;
                  cnt            <= '0;
                  ready          <= 1'b0;
                  mem_beat_ready <= 1'b1;
                  state          <= REFILL;
               end
            end
            REFILL: begin
               if (mem_beat_valid) begin
                  if (cnt == LAST) begin
                     cnt            <= '0;
                     mem_beat_ready <= 1'b0;
                     done_pend      <= 1'b1;
                     state          <= IDLE;
                  end else begin
                     cnt <= cnt_nxt;
                  end
               end
            end
            EV_RD: begin
               cnt   <= '0;
               perr  <= par_bad;
               state <= EV_SEND;
            end
            EV_SEND: begin
               if (!wb_beat_valid) begin
                  wb_beat_valid <= 1'b1;
                  wb_beat_data  <= stage[0];
                  wb_beat_last  <= 1'b0;
               end else if (wb_beat_ready) begin
                  if (cnt == LAST) begin
                     wb_beat_valid <= 1'b0;
                     wb_beat_last  <= 1'b0;
                     wb_beat_data  <= '0;
                     cnt           <= '0;
                     ready         <= 1'b1;
                     state         <= IDLE;
                  end else begin
                     cnt          <= cnt_nxt;
                     wb_beat_data <= stage[cnt_nxt];
                     wb_beat_last <= (cnt_nxt == LAST);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_data_array_bw.sv
// Scoreboard bench for l2_data_array_bw (default geometry 512/128/256/4).
// Parity corruption check runs only when L2_DATA_PARITY_EN is defined.
module tb_l2_data_array_bw;

   localparam int LW = 512, BW = 128, BEATS = 4, WAYS = 4, NB = 64;

   logic            clk = 1'b0, nrst = 1'b0;
   logic [7:0]      index = '0;
   logic [1:0]      way = '0;
   logic            rd_req = 0, upd_req = 0, refill_start = 0, evict_start = 0;
   logic [LW-1:0]   upd_data = '0;
   logic [NB-1:0]   upd_be = '0;
   logic            ready, rd_valid, mem_beat_ready, refill_done;
   logic [LW-1:0]   rd_data;
   logic            mem_beat_valid = 0;
   logic [BW-1:0]   mem_beat_data = '0;
   logic            wb_beat_valid, wb_beat_last, perr;
   logic [BW-1:0]   wb_beat_data;
   logic            wb_beat_ready = 0;

   int              n_chk = 0, n_err = 0;
   logic [LW-1:0]   model [int];
   logic [LW-1:0]   rd_q [$];
   logic [BW-1:0]   wb_q [$];
   int              ev_k = 0;
   logic            hold_pend = 0;
   logic [BW-1:0]   hold_d;

   l2_data_array_bw dut (
      .clk(clk), .nrst(nrst), .index(index), .way(way),
      .rd_req(rd_req), .upd_req(upd_req), .upd_data(upd_data), .upd_be(upd_be),
      .refill_start(refill_start), .evict_start(evict_start), .ready(ready),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .mem_beat_valid(mem_beat_valid), .mem_beat_data(mem_beat_data),
      .mem_beat_ready(mem_beat_ready), .refill_done(refill_done),
      .wb_beat_valid(wb_beat_valid), .wb_beat_data(wb_beat_data),
      .wb_beat_last(wb_beat_last), .wb_beat_ready(wb_beat_ready), .perr(perr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rst_outs();
      chk("rst_ready", ready, 1'b1);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_rd_data", rd_data, '0);
      chk("rst_mbr", mem_beat_ready, 1'b0);
      chk("rst_done", refill_done, 1'b0);
      chk("rst_wb_valid", wb_beat_valid, 1'b0);
      chk("rst_wb_last", wb_beat_last, 1'b0);
      chk("rst_wb_data", wb_beat_data, '0);
      chk("rst_perr", perr, 1'b0);
   endtask

   // Output monitor: read responses and write-back beats against the queues.
   always @(negedge clk) begin
      logic [LW-1:0] e;
      logic [BW-1:0] eb;
      if (nrst) begin
         if (rd_valid) begin
            if (rd_q.size() == 0) chk("rd_unexp", rd_valid, 1'b0);
            else begin
               e = rd_q.pop_front();
               chk("rd_data", rd_data, e);
            end
         end
         if (hold_pend) begin
            chk("wb_hold_v", wb_beat_valid, 1'b1);
            chk("wb_hold_d", wb_beat_data, hold_d);
         end
         if (wb_beat_valid && wb_beat_ready) begin
            hold_pend = 0;
            if (wb_q.size() == 0) chk("wb_unexp", wb_beat_valid, 1'b0);
            else begin
               eb = wb_q.pop_front();
               chk("wb_data", wb_beat_data, eb);
               chk("wb_last", wb_beat_last, ev_k == BEATS - 1);
               ev_k = (ev_k == BEATS - 1) ? 0 : ev_k + 1;
            end
         end else if (wb_beat_valid) begin
            hold_pend = 1;
            hold_d    = wb_beat_data;
         end else begin
            hold_pend = 0;
         end
      end
   end

   task automatic do_upd(input int idx, input int w, input logic [LW-1:0] d, input logic [NB-1:0] be);
      logic [LW-1:0] l;
      index = 8'(idx); way = 2'(w); upd_data = d; upd_be = be; upd_req = 1;
      tick();
      upd_req = 0;
      l = model.exists(idx*WAYS+w) ? model[idx*WAYS+w] : '0;
      for (int b = 0; b < NB; b++) if (be[b]) l[b*8 +: 8] = d[b*8 +: 8];
      model[idx*WAYS+w] = l;
   endtask

   task automatic do_read(input int idx, input int w, input logic exp_perr);
      index = 8'(idx); way = 2'(w); rd_req = 1;
      rd_q.push_back(model[idx*WAYS+w]);
      tick();
      rd_req = 0;
      chk("rd_early", rd_valid, 1'b0);
      tick();
      chk("rd_valid", rd_valid, 1'b1);
      chk("rd_perr", perr, exp_perr);
      tick();
      chk("rd_pulse", rd_valid, 1'b0);
   endtask

   task automatic do_refill(input int idx, input int w, input logic gaps);
      logic [LW-1:0] l;
      logic [7:0]    bv;
      index = 8'(idx); way = 2'(w); refill_start = 1;
      tick();
      refill_start = 0;
      chk("rf_ready_lo", ready, 1'b0);
      chk("rf_mbr", mem_beat_ready, 1'b1);
      for (int k = 0; k < BEATS; k++) begin
         if (gaps && (k % 2 == 1)) begin
            mem_beat_valid = 0;
            tick();
         end
         bv = 8'((k + 1) * 17);
         mem_beat_data = {16{bv}};
         l[k*BW +: BW] = mem_beat_data;
         mem_beat_valid = 1;
         tick();
      end
      mem_beat_valid = 0;
      chk("rf_done_early", refill_done, 1'b0);
      chk("rf_ready_early", ready, 1'b0);
      tick();
      chk("rf_done", refill_done, 1'b1);
      chk("rf_ready", ready, 1'b1);
      chk("rf_mbr_off", mem_beat_ready, 1'b0);
      tick();
      chk("rf_done_pulse", refill_done, 1'b0);
      model[idx*WAYS+w] = l;
   endtask

   task automatic do_evict(input int idx, input int w, input logic toggle, input logic others);
      int cyc;
      for (int k = 0; k < BEATS; k++) wb_q.push_back(model[idx*WAYS+w][k*BW +: BW]);
      index = 8'(idx); way = 2'(w); evict_start = 1;
      rd_req = others; upd_req = others; upd_data = '0; upd_be = '1;
      tick();
      evict_start = 0; rd_req = 0; upd_req = 0;
      cyc = 0;
      while (cyc < 40) begin
         wb_beat_ready = toggle ? cyc[0] : 1'b1;
         tick();
         cyc++;
         if (cyc == 1) chk("ev_v_t1", wb_beat_valid, 1'b0);
         if (cyc == 2) chk("ev_v_t2", wb_beat_valid, 1'b1);
         if (ready) break;
      end
      wb_beat_ready = 0;
      if (!toggle) chk("ev_cycles", cyc, BEATS + 2);
      chk("ev_ready", ready, 1'b1);
      chk("ev_left", wb_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NB-1:0] be_lo;
      repeat (2) @(posedge clk);
      #1;
      chk_rst_outs();
      nrst = 1;
      tick();

      // Full update then byte-masked update, each read back.
      do_upd(3, 1, {64{8'hA5}}, '1);
      do_read(3, 1, 1'b0);
      be_lo = '0;
      be_lo[7:0] = 8'hFF;
      do_upd(3, 1, {64{8'hFF}}, be_lo);
      do_read(3, 1, 1'b0);

      // Refill with gaps, read back, then evict with stalls.
      do_refill(7, 2, 1'b1);
      do_read(7, 2, 1'b0);
      do_evict(7, 2, 1'b1, 1'b0);

      // Simultaneous evict/update/read: eviction only, update and read dropped.
      do_evict(3, 1, 1'b0, 1'b1);
      tick();
      do_read(3, 1, 1'b0);

      // Reset during beat 2 of a refill over index 3 way 1.
      index = 8'd3; way = 2'd1; refill_start = 1;
      tick();
      refill_start = 0;
      for (int k = 0; k < 2; k++) begin
         mem_beat_data = {BW{1'b1}} ^ BW'(k);
         mem_beat_valid = 1;
         tick();
      end
      mem_beat_data = '0;
      nrst = 0;
      #2;
      chk_rst_outs();
      nrst = 1;
      tick();
      tick();
      mem_beat_valid = 0;
      chk("post_rst_ready", ready, 1'b1);
      chk("post_rst_mbr", mem_beat_ready, 1'b0);
      do_read(3, 1, 1'b0);

`ifdef L2_DATA_PARITY_EN
      dut.u_ram.par_mem[3*WAYS+1][0] = ~dut.u_ram.par_mem[3*WAYS+1][0];
      do_read(3, 1, 1'b1);
`else
      do_read(7, 2, 1'b0);
`endif

      repeat (3) tick();
      chk("rd_left", rd_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
